pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one datapath word.
REQ-002 SHALL have parameter NUM_WORDS, default 4: number of datapath words carried (pc, ALU result, RT data, instr).
REQ-003 SHALL have parameter CTRL_W, default 6: control bits carried (MemtoReg, RegWrite, Branch, MemWrite, MemRead, zero).
REQ-004 SHALL have parameter SKID, default 1: 1 selects a 2-entry skid stage, 0 selects a 1-entry stall register.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port flush_i, input, 1 bit: kills all held entries and any same-cycle input.
REQ-008 SHALL have port valid_i, input, 1 bit: upstream payload valid.
REQ-009 SHALL have port ready_o, output, 1 bit: stage accepts a payload this cycle.
REQ-010 SHALL have port ctrl_i, input, CTRL_W bits: upstream control bits.
REQ-011 SHALL have port data_i, input, NUM_WORDS*DATA_W bits: upstream words, word k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port valid_o, output, 1 bit: downstream payload valid.
REQ-013 SHALL have port ready_i, input, 1 bit: downstream accepts the payload.
REQ-014 SHALL have port ctrl_o, output, CTRL_W bits: control bits; all zero whenever valid_o=0.
REQ-015 SHALL have port data_o, output, NUM_WORDS*DATA_W bits: downstream words.
REQ-016 SHALL have port count_o, output, 2 bits: number of entries held (0..2; 0..1 when SKID=0).

Function
REQ-017 An accept SHALL occur when valid_i & ready_o, and a release SHALL occur when valid_o & ready_i.
REQ-018 Latency from accept to valid_o SHALL be exactly 1 cycle when the stage is empty, and sustained throughput SHALL be 1 payload/cycle.
REQ-019 SKID=1: ready_o SHALL equal ~skid_valid & ~rst_i and SHALL be registered-only (no combinational path from ready_i).
REQ-020 SKID=1 with the output entry empty or releasing: the output entry SHALL load from the skid entry if it is valid, else from the input on accept.
REQ-021 SKID=1 with the output entry held (valid_o & ~ready_i) and an accept: the payload SHALL go to the skid entry; the output SHALL be unchanged.
REQ-022 SKID=1: an accept with the skid entry full SHALL be impossible (ready_o=0), and order SHALL always be preserved (skid entry released after output entry).
REQ-023 SKID=0: ready_o SHALL equal (ready_i | ~valid_o) & ~rst_i; the entry SHALL load on accept and hold otherwise.
REQ-024 flush_i=1 SHALL clear valid_o, the skid entry, ctrl_o and count_o at the next edge, and any same-cycle accept SHALL be discarded.
REQ-025 A release presented in the flush cycle SHALL count as delivered; data_o MAY retain its stale value after flush.
REQ-026 count_o SHALL update each edge as +1 on accept only, -1 on release only, and unchanged on both or neither.
REQ-027 Simultaneous accept and release at count 2 SHALL not occur; at count 1 with both, count SHALL stay 1 and the new payload SHALL go to the output entry.

Reset
REQ-028 rst_i=1 at an edge SHALL set valid_o=0, ctrl_o=0, data_o=0, count_o=0 and the skid entry invalid and zero.
REQ-029 rst_i SHALL take priority over flush_i and over any accept/release, and ready_o SHALL be 0 while rst_i=1.
REQ-030 Reset asserted mid-stream SHALL drop all held payloads without a release.

Structure
REQ-031 The shared package pipe_pkg SHALL hold default DATA_W/NUM_WORDS/CTRL_W and the ctrl bit-index constants (MEMTOREG=0, REGWRITE=1, BRANCH=2, MEMWRITE=3, MEMREAD=4, ZERO=5).
REQ-032 One sub-module, pipe_slot (valid + ctrl + data register with load/clear), SHALL be instantiated once (SKID=0) or twice (SKID=1).

Verification
REQ-033 Stream 0x10,0x14,0x18 with ready_i=1 SHALL produce valid_o one cycle after each accept, data word0 in order, and count_o=1 throughout.
REQ-034 Accept 0xA then 0xB with ready_i=0 (SKID=1) SHALL give count_o=2 and ready_o=0; raising ready_i SHALL release 0xA then 0xB on consecutive cycles.
REQ-035 Flush with count_o=2 and valid_i=1 (0xC) SHALL give valid_o=0, ctrl_o=0 and count_o=0 next cycle, and 0xC SHALL never appear.
REQ-036 rst_i pulse while holding ctrl=6'b010011 SHALL give all outputs 0 next cycle and ready_o=0 during the pulse.
REQ-037 SKID=0 with ready_i toggling 1,0,1 and valid_i=1 SHALL show no loss or duplication and ready_o tracking ready_i|~valid_o.
REQ-038 Simultaneous rst_i and flush_i SHALL yield reset values with no release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline defaults and control-bit indices.
// Imported by the skid/stall stage and its storage slot.
package pipe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 4;
  localparam int CTRL_W_DEF    = 6;

  localparam int MEMTOREG = 0;
  localparam int REGWRITE = 1;
  localparam int BRANCH   = 2;
  localparam int MEMWRITE = 3;
  localparam int MEMREAD  = 4;
  localparam int ZERO     = 5;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + ctrl + data with load/clear.
// Ports: clk_i, rst_i (sync), clr_i (drop valid+ctrl),
//   load_i, ctrl_i/data_i in, valid_o/ctrl_o/data_o held.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DW     = DATA_W_DEF * NUM_WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DW-1:0]     data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DW-1:0]     data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DW-1:0]     data_d, data_q;

  // Clear wins over load; data is left stale on clear.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage: 2-entry skid (SKID=1) or 1-entry stall.
// Ports: valid_i/ready_o/ctrl_i/data_i upstream, valid_o/ready_i/
//   ctrl_o/data_o downstream, flush_i kill, count_o occupancy.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int CTRL_W    = CTRL_W_DEF,
  parameter int SKID      = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [CTRL_W-1:0]           ctrl_i,
  input  logic [NUM_WORDS*DATA_W-1:0] data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [CTRL_W-1:0]           ctrl_o,
  output logic [NUM_WORDS*DATA_W-1:0] data_o,
  output logic [1:0]                  count_o
);

  localparam int DW = NUM_WORDS * DATA_W;

  logic              acc;
  logic              rel;
  logic              out_v;
  logic [CTRL_W-1:0] out_c;
  logic [DW-1:0]     out_d;
  logic              out_load;
  logic              out_clr;
  logic [CTRL_W-1:0] out_lc;
  logic [DW-1:0]     out_ld;
  logic              sk_v;

  assign acc = valid_i & ready_o;
  assign rel = out_v & ready_i;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DW     (DW)
  ) u_out (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (out_clr),
    .load_i  (out_load),
    .ctrl_i  (out_lc),
    .data_i  (out_ld),
    .valid_o (out_v),
    .ctrl_o  (out_c),
    .data_o  (out_d)
  );

  if (SKID != 0) begin : g_skid
    logic              out_free;
    logic              sk_load;
    logic              sk_clr;
    logic [CTRL_W-1:0] sk_c;
    logic [DW-1:0]     sk_d;

    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DW     (DW)
    ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (sk_clr),
      .load_i  (sk_load),
      .ctrl_i  (ctrl_i),
      .data_i  (data_i),
      .valid_o (sk_v),
      .ctrl_o  (sk_c),
      .data_o  (sk_d)
    );

    // Output entry refills from skid first so order holds;
    // an accept only parks in skid while output is stalled.
    always_comb begin
      out_free = ~out_v | ready_i;
      out_load = ~flush_i & out_free & (sk_v | acc);
      out_clr  = flush_i | (rel & ~out_load);
      out_lc   = sk_v ? sk_c : ctrl_i;
      out_ld   = sk_v ? sk_d : data_i;
      sk_load  = ~flush_i & acc & ~out_free;
      sk_clr   = flush_i | (out_free & sk_v);
    end

    // Depends only on state, not on ready_i.
    assign ready_o = ~sk_v & ~rst_i;
  end else begin : g_stall
    assign sk_v = 1'b0;

    always_comb begin
      out_load = ~flush_i & acc;
      out_clr  = flush_i | (rel & ~acc);
      out_lc   = ctrl_i;
      out_ld   = data_i;
    end

    assign ready_o = (ready_i | ~out_v) & ~rst_i;
  end

  assign valid_o = out_v;
  assign ctrl_o  = out_c;
  assign data_o  = out_d;
  assign count_o = 2'(out_v) + 2'(sk_v);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage, SKID=1 and SKID=0.
// Both instances share stimulus; each has its own queue model.
module tb_pipe_skid_stage;

  localparam int DW = 128;
  localparam int CW = 6;
  localparam int PW = CW + DW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          valid_i;
  logic          ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          ro   [2];
  logic          vo   [2];
  logic [CW-1:0] co   [2];
  logic [DW-1:0] dout [2];
  logic [1:0]    cnt  [2];

  logic [PW-1:0] q [2][$];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.SKID(1)) u_skid (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ro[0]),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .valid_o (vo[0]),
    .ready_i (ready_i),
    .ctrl_o  (co[0]),
    .data_o  (dout[0]),
    .count_o (cnt[0])
  );

  pipe_skid_stage #(.SKID(0)) u_stall (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ro[1]),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .valid_o (vo[1]),
    .ready_i (ready_i),
    .ctrl_o  (co[1]),
    .data_o  (dout[1]),
    .count_o (cnt[1])
  );

  task automatic chk(input string nm, input int d,
                     input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d @%0t: got %h want %h",
               nm, d, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs; log accepted payloads.
  task automatic cyc(input logic rs, input logic fl,
                     input logic v, input logic r,
                     input logic [31:0] w0,
                     input logic [CW-1:0] c);
    @(negedge clk);
    rst_i   = rs;
    flush_i = fl;
    valid_i = v;
    ready_i = r;
    ctrl_i  = c;
    data_i  = {$urandom, $urandom, $urandom, w0};
    #3;
    for (int d = 0; d < 2; d++)
      if (v && ro[d] && !rs && !fl)
        q[d].push_back({c, data_i});
  endtask

  // Monitor: expected state derives from queue occupancy.
  initial begin : mon
    int   n;
    logic er;
    logic after_rst;
    after_rst = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        n = q[d].size();
        if (d == 0) er = !rst_i && (n < 2);
        else er = !rst_i && (ready_i || n == 0);
        chk("ready_o", d, PW'(ro[d]), PW'(er));
        chk("valid_o", d, PW'(vo[d]), PW'(n != 0));
        chk("count_o", d, PW'(cnt[d]), PW'(n));
        if (n != 0)
          chk("payload", d, {co[d], dout[d]}, q[d][0]);
        else
          chk("ctrl_idle", d, PW'(co[d]), '0);
        if (after_rst)
          chk("rst_data", d, PW'(dout[d]), '0);
        if (rst_i || flush_i)
          q[d].delete();
        else if (vo[d] && ready_i && n != 0)
          void'(q[d].pop_front());
      end
      after_rst = rst_i;
    end
  end

  initial begin
    logic          rs, fl, v, r;
    logic [CW-1:0] c;
    rst_i   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    ctrl_i  = '0;
    data_i  = '0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // streaming with ready high
    cyc(0, 0, 1, 1, 32'h10, 6'h03);
    cyc(0, 0, 1, 1, 32'h14, 6'h21);
    cyc(0, 0, 1, 1, 32'h18, 6'h12);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // fill skid, then drain
    cyc(0, 0, 1, 0, 32'hA, 6'h01);
    cyc(0, 0, 1, 0, 32'hB, 6'h02);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // flush while full with input valid
    cyc(0, 0, 1, 0, 32'hA, 6'h01);
    cyc(0, 0, 1, 0, 32'hB, 6'h02);
    cyc(0, 1, 1, 0, 32'hC, 6'h3f);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // reset pulse while holding
    cyc(0, 0, 1, 0, 32'h5, 6'b010011);
    cyc(1, 0, 1, 1, 32'h6, 6'b010011);
    cyc(0, 0, 0, 1, 0, 0);
    // reset and flush together
    cyc(0, 0, 1, 0, 32'h7, 6'h11);
    cyc(0, 0, 1, 0, 32'h8, 6'h22);
    cyc(1, 1, 1, 1, 32'h9, 6'h33);
    cyc(0, 0, 0, 1, 0, 0);
    // ready toggling 1,0,1 with valid held
    cyc(0, 0, 1, 1, 32'h20, 6'h04);
    cyc(0, 0, 1, 0, 32'h24, 6'h08);
    cyc(0, 0, 1, 1, 32'h28, 6'h10);
    cyc(0, 0, 1, 1, 32'h2c, 6'h20);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom % 200) == 0;
      fl = ($urandom % 50) == 0;
      v  = ($urandom % 4) != 0;
      r  = ($urandom % 3) != 0;
      c  = CW'($urandom);
      cyc(rs, fl, v, r, $urandom, c);
    end
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
